reg_dc_pipe: RTL and testbench
==============================

Name: reg_dc_pipe

Overview:
Parametrised register-read decode stage feeding the ALU/execute stage. It provides two read ports into an N-entry register file presented as a flat bus, with write-back bypass and optional hard-zero R0. A single valid/ready pipeline register carries the decoded operands and register numbers, with flush support. While a stage is stalled, any write-back to a held register updates the held operand, so held operands never go stale.

Parameters:
DATA_W, 16, register data width in bits
N_REGS, 8, number of architectural registers (2..64, need not be a power of 2)
SEL_W, 3, selector width; must equal max(1, ceil(log2(N_REGS)))
ZERO_R0, 0, 1 = register 0 always reads as zero, overriding bypass

Ports:
CLK_DC  in  1  stage clock, rising edge
RST_DC  in  1  asynchronous reset, active-high
REGS_IN  in  N_REGS*DATA_W  flat register file; entry k is bits [k*DATA_W +: DATA_W]
IN_VALID  in  1  upstream holds a valid decode request
IN_READY  out  1  stage can accept a request this cycle
N_REG_A_IN  in  SEL_W  port A register number
N_REG_B_IN  in  SEL_W  port B register number
FLUSH  in  1  discard stage contents and the current input
WB_EN  in  1  write-back strobe this cycle
WB_N  in  SEL_W  write-back register number
WB_DATA  in  DATA_W  write-back data
OUT_VALID  out  1  stage holds valid operands
OUT_READY  in  1  downstream consumes this cycle
N_REG_A_OUT  out  SEL_W  registered port A number
N_REG_B_OUT  out  SEL_W  registered port B number
REG_A_OUT  out  DATA_W  registered port A operand
REG_B_OUT  out  DATA_W  registered port B operand
SEL_ERR  out  1  registered; a captured selector was >= N_REGS

Behaviour:
- Clocking: one clock (CLK_DC). RST_DC is asynchronous and active-high.
- Reset: all registered outputs = 0, including OUT_VALID, N_REG_*_OUT, REG_*_OUT and SEL_ERR. The first capture is on the first rising edge after RST_DC deasserts.
- IN_READY (combinational) = !OUT_VALID | OUT_READY. There is no combinational path from IN_VALID to IN_READY.
- Per-port read value rd(sel), evaluated in this priority order:
  - ZERO_R0 && sel==0 -> 0.
  - sel >= N_REGS -> 0, and the error flag is raised.
  - WB_EN && WB_N==sel -> WB_DATA (same-cycle bypass).
  - otherwise REGS_IN entry sel.
- Write-back into an out-of-range WB_N is ignored.
- Per rising edge, evaluated in priority order:
  1. FLUSH: OUT_VALID <= 0; data, register numbers and SEL_ERR <= 0. The input is not accepted, regardless of IN_VALID/IN_READY.
  2. Capture, when IN_VALID && IN_READY:
     - OUT_VALID <= 1
     - N_REG_A_OUT <= N_REG_A_IN; N_REG_B_OUT <= N_REG_B_IN
     - REG_A_OUT <= rd(A); REG_B_OUT <= rd(B)
     - SEL_ERR <= error flag of A | error flag of B
  3. Drain, when OUT_READY && !IN_VALID: OUT_VALID <= 0. Data is held, don't-care.
  4. Hold, when OUT_VALID && !OUT_READY:
     - All fields keep their values, except for the held-operand refresh below.
     - If WB_EN && WB_N==N_REG_A_OUT and the ZERO_R0-zero rule does not apply, REG_A_OUT <= WB_DATA. Port B is handled identically and independently.
- Latency: 1 cycle from accepted request to OUT_VALID. Throughput is 1 per cycle when OUT_READY stays high.
- Both ports may select the same register; both then receive the identical value.
- Simultaneous capture and write-back to the selected register: the bypass value wins.
- Reset mid-stall: contents are lost and OUT_VALID=0 immediately (asynchronous).

Decomposition:
- Package reg_dc_pkg holds:
  - default constants DATA_W_DEF=16, N_REGS_DEF=8;
  - function sel_width(n) returning the selector width;
  - localparam for the hard-zero register index (0).
- One sub-module, reg_dc_rdport: combinational read port containing the mux, range check, bypass compare and zero override. Parameters DATA_W, N_REGS, SEL_W, ZERO_R0. It is instantiated twice (ports A and B) and once more for each held-operand refresh compare, or the compare is shared.
- All state lives in reg_dc_pipe.

Test Plan:
- Reset/basic read: REGS_IN entries = 16'h1000+k; issue A=3, B=5 with OUT_READY=1. Next edge: OUT_VALID=1, REG_A_OUT=16'h1003, REG_B_OUT=16'h1005, N_REG_A_OUT=3. Assert RST_DC mid-cycle -> all outputs 0 without waiting for a clock edge.
- Bypass: A=2, WB_EN=1, WB_N=2, WB_DATA=16'hBEEF in the same cycle -> REG_A_OUT=16'hBEEF; port B reading 2 also gets 16'hBEEF.
- Stall + refresh: capture A=4 (16'h1004), then OUT_READY=0 for 3 cycles with a write-back of 16'h00AA to r4 in cycle 2. REG_A_OUT becomes 16'h00AA and stays there; IN_READY=0 throughout; new IN_VALID requests are not accepted.
- Flush: with OUT_VALID=1 and OUT_READY=0, pulse FLUSH while IN_VALID=1 -> next edge OUT_VALID=0, outputs 0, and the input is not captured.
- ZERO_R0=1: A=0 with a write-back of 16'h1234 to r0 -> REG_A_OUT=0. With ZERO_R0=0 the same stimulus gives 16'h1234.
- N_REGS=6, SEL_W=3: A=7 -> REG_A_OUT=0, SEL_ERR=1. The next capture with A=1 -> SEL_ERR=0. A back-to-back stream of 8 requests with OUT_READY=1 yields 8 consecutive OUT_VALID cycles.

Source files
------------

// File: rtl/reg_dc_pkg.sv
// Shared constants and helpers for the register-read decode stage.
package reg_dc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int N_REGS_DEF = 8;
  localparam int ZERO_REG   = 0;

  // Selector width for n registers: ceil(log2(n)), never below 1.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_dc_rdport.sv
// Combinational register read port: entry mux, range check, write-back bypass
// and optional hard-zero override of register 0.
module reg_dc_rdport
  import reg_dc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_REGS  = N_REGS_DEF,
  parameter int SEL_W   = sel_width(N_REGS),
  parameter int ZERO_R0 = 0
) (
  input  logic [N_REGS*DATA_W-1:0] regs,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     wb_en,
  input  logic [SEL_W-1:0]         wb_n,
  input  logic [DATA_W-1:0]        wb_data,
  output logic [DATA_W-1:0]        data,
  output logic                     err,
  output logic                     hit
);

  logic [31:0]       sel_u;
  logic              zero;
  logic              range_bad;
  logic [DATA_W-1:0] entry;

  always_comb begin
    sel_u     = 32'(sel);
    zero      = (ZERO_R0 != 0) && (sel_u == 32'(ZERO_REG));
    range_bad = sel_u >= 32'(N_REGS);
    entry     = '0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      if (sel_u == k) entry = regs[k*DATA_W +: DATA_W];
    end
    // hit doubles as the held-operand refresh condition
    hit  = wb_en && (wb_n == sel) && !zero && !range_bad;
    err  = !zero && range_bad;
    if (zero || range_bad) data = '0;
    else if (hit)          data = wb_data;
    else                   data = entry;
  end

endmodule

// File: rtl/reg_dc_pipe.sv
// Register-read decode stage: two bypassed read ports feeding one valid/ready
// pipeline register with flush and stall-time operand refresh.
module reg_dc_pipe
  import reg_dc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_REGS  = N_REGS_DEF,
  parameter int SEL_W   = sel_width(N_REGS),
  parameter int ZERO_R0 = 0
) (
  input  logic                     CLK_DC,
  input  logic                     RST_DC,
  input  logic [N_REGS*DATA_W-1:0] REGS_IN,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [SEL_W-1:0]         N_REG_A_IN,
  input  logic [SEL_W-1:0]         N_REG_B_IN,
  input  logic                     FLUSH,
  input  logic                     WB_EN,
  input  logic [SEL_W-1:0]         WB_N,
  input  logic [DATA_W-1:0]        WB_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [SEL_W-1:0]         N_REG_A_OUT,
  output logic [SEL_W-1:0]         N_REG_B_OUT,
  output logic [DATA_W-1:0]        REG_A_OUT,
  output logic [DATA_W-1:0]        REG_B_OUT,
  output logic                     SEL_ERR
);

  logic [DATA_W-1:0] rd_a_data, rd_b_data, ref_a_data, ref_b_data;
  logic              rd_a_err, rd_b_err, ref_a_err, ref_b_err;
  logic              rd_a_hit, rd_b_hit, ref_a_hit, ref_b_hit;
  logic              unused_flags;

  assign IN_READY     = !OUT_VALID || OUT_READY;
  assign unused_flags = rd_a_hit | rd_b_hit | ref_a_err | ref_b_err
                      | (|ref_a_data) | (|ref_b_data);

  reg_dc_rdport #(.DATA_W(DATA_W), .N_REGS(N_REGS), .SEL_W(SEL_W), .ZERO_R0(ZERO_R0)) u_rd_a (
    .regs(REGS_IN), .sel(N_REG_A_IN), .wb_en(WB_EN), .wb_n(WB_N), .wb_data(WB_DATA),
    .data(rd_a_data), .err(rd_a_err), .hit(rd_a_hit)
  );

  reg_dc_rdport #(.DATA_W(DATA_W), .N_REGS(N_REGS), .SEL_W(SEL_W), .ZERO_R0(ZERO_R0)) u_rd_b (
    .regs(REGS_IN), .sel(N_REG_B_IN), .wb_en(WB_EN), .wb_n(WB_N), .wb_data(WB_DATA),
    .data(rd_b_data), .err(rd_b_err), .hit(rd_b_hit)
  );

  // Refresh ports look at the held register numbers; only their hit is used.
  reg_dc_rdport #(.DATA_W(DATA_W), .N_REGS(N_REGS), .SEL_W(SEL_W), .ZERO_R0(ZERO_R0)) u_ref_a (
    .regs(REGS_IN), .sel(N_REG_A_OUT), .wb_en(WB_EN), .wb_n(WB_N), .wb_data(WB_DATA),
    .data(ref_a_data), .err(ref_a_err), .hit(ref_a_hit)
  );

  reg_dc_rdport #(.DATA_W(DATA_W), .N_REGS(N_REGS), .SEL_W(SEL_W), .ZERO_R0(ZERO_R0)) u_ref_b (
    .regs(REGS_IN), .sel(N_REG_B_OUT), .wb_en(WB_EN), .wb_n(WB_N), .wb_data(WB_DATA),
    .data(ref_b_data), .err(ref_b_err), .hit(ref_b_hit)
  );

  always_ff @(posedge CLK_DC or posedge RST_DC) begin
    if (RST_DC) begin
      OUT_VALID   <= 1'b0;
      N_REG_A_OUT <= '0;
      N_REG_B_OUT <= '0;
      REG_A_OUT   <= '0;
      REG_B_OUT   <= '0;
      SEL_ERR     <= 1'b0;
    end else if (FLUSH) begin
      OUT_VALID   <= 1'b0;
      N_REG_A_OUT <= '0;
      N_REG_B_OUT <= '0;
      REG_A_OUT   <= '0;
      REG_B_OUT   <= '0;
      SEL_ERR     <= 1'b0;
    end else if (IN_VALID && IN_READY) begin
      OUT_VALID   <= 1'b1;
      N_REG_A_OUT <= N_REG_A_IN;
      N_REG_B_OUT <= N_REG_B_IN;
      REG_A_OUT   <= rd_a_data;
      REG_B_OUT   <= rd_b_data;
      SEL_ERR     <= rd_a_err | rd_b_err;
    end else if (OUT_READY && !IN_VALID) begin
      OUT_VALID   <= 1'b0;
    end else if (OUT_VALID && !OUT_READY) begin
      if (ref_a_hit) REG_A_OUT <= WB_DATA;
      if (ref_b_hit) REG_B_OUT <= WB_DATA;
    end
  end

endmodule

// File: tb/tb_reg_dc_pipe.sv
// Bench for reg_dc_pipe: three instances (default, ZERO_R0=1, N_REGS=6) share
// stimulus and are checked against a transaction-level model.
module tb_reg_dc_pipe;

  typedef struct {
    logic [2:0]  a, b;
    logic        wb_en;
    logic [2:0]  wb_n;
    logic [15:0] wb_data;
    logic [15:0] ea, eb, ez, e6;
    logic        e6err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rf [8];
  logic [127:0] regs_flat;
  logic [95:0]  regs6;
  logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [2:0]  a = '0, b = '0, wb_n = '0;
  logic [15:0] wb_data = '0;

  logic [2:0]        ir, ov, se;
  logic [2:0][2:0]   na, nb;
  logic [2:0][15:0]  da, db;

  logic        m_valid [3];
  logic [2:0]  m_na [3], m_nb [3];
  logic [15:0] m_da [3], m_db [3];
  logic        m_err [3];

  int n_vec = 0;
  int n_bad = 0;
  vec_t tab [6];

  always #5 clk = ~clk;

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < 8; k++) regs_flat[k*16 +: 16] = rf[k];
  end
  assign regs6 = regs_flat[95:0];

  reg_dc_pipe #(.DATA_W(16), .N_REGS(8), .SEL_W(3), .ZERO_R0(0)) dut (
    .CLK_DC(clk), .RST_DC(rst), .REGS_IN(regs_flat), .IN_VALID(in_valid), .IN_READY(ir[0]),
    .N_REG_A_IN(a), .N_REG_B_IN(b), .FLUSH(flush), .WB_EN(wb_en), .WB_N(wb_n), .WB_DATA(wb_data),
    .OUT_VALID(ov[0]), .OUT_READY(out_ready), .N_REG_A_OUT(na[0]), .N_REG_B_OUT(nb[0]),
    .REG_A_OUT(da[0]), .REG_B_OUT(db[0]), .SEL_ERR(se[0])
  );

  reg_dc_pipe #(.DATA_W(16), .N_REGS(8), .SEL_W(3), .ZERO_R0(1)) dut_z (
    .CLK_DC(clk), .RST_DC(rst), .REGS_IN(regs_flat), .IN_VALID(in_valid), .IN_READY(ir[1]),
    .N_REG_A_IN(a), .N_REG_B_IN(b), .FLUSH(flush), .WB_EN(wb_en), .WB_N(wb_n), .WB_DATA(wb_data),
    .OUT_VALID(ov[1]), .OUT_READY(out_ready), .N_REG_A_OUT(na[1]), .N_REG_B_OUT(nb[1]),
    .REG_A_OUT(da[1]), .REG_B_OUT(db[1]), .SEL_ERR(se[1])
  );

  reg_dc_pipe #(.DATA_W(16), .N_REGS(6), .SEL_W(3), .ZERO_R0(0)) dut_6 (
    .CLK_DC(clk), .RST_DC(rst), .REGS_IN(regs6), .IN_VALID(in_valid), .IN_READY(ir[2]),
    .N_REG_A_IN(a), .N_REG_B_IN(b), .FLUSH(flush), .WB_EN(wb_en), .WB_N(wb_n), .WB_DATA(wb_data),
    .OUT_VALID(ov[2]), .OUT_READY(out_ready), .N_REG_A_OUT(na[2]), .N_REG_B_OUT(nb[2]),
    .REG_A_OUT(da[2]), .REG_B_OUT(db[2]), .SEL_ERR(se[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nregs_of(input int i);
    return (i == 2) ? 6 : 8;
  endfunction

  // Operand value for a selector under instance i's parameters.
  function automatic logic [15:0] rd(input int i, input logic [2:0] s, output logic e);
    e = 1'b0;
    if (i == 1 && s == 3'd0) return 16'h0;
    if (int'(s) >= nregs_of(i)) begin
      e = 1'b1;
      return 16'h0;
    end
    if (wb_en && wb_n == s) return wb_data;
    return rf[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0; m_na[i] = '0; m_nb[i] = '0;
      m_da[i] = '0; m_db[i] = '0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      logic ea, eb;
      logic wb_ok;
      wb_ok = wb_en && (int'(wb_n) < nregs_of(i));
      if (flush) begin
        m_valid[i] = 1'b0; m_na[i] = '0; m_nb[i] = '0;
        m_da[i] = '0; m_db[i] = '0; m_err[i] = 1'b0;
      end else if (in_valid && (!m_valid[i] || out_ready)) begin
        m_valid[i] = 1'b1;
        m_na[i] = a;
        m_nb[i] = b;
        m_da[i] = rd(i, a, ea);
        m_db[i] = rd(i, b, eb);
        m_err[i] = ea | eb;
      end else if (out_ready && !in_valid) begin
        m_valid[i] = 1'b0;
      end else if (m_valid[i] && !out_ready) begin
        if (wb_ok && wb_n == m_na[i] && !(i == 1 && m_na[i] == 3'd0)) m_da[i] = wb_data;
        if (wb_ok && wb_n == m_nb[i] && !(i == 1 && m_nb[i] == 3'd0)) m_db[i] = wb_data;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(m_valid[i]));
      chk($sformatf("in_ready%0d", i), 32'(ir[i]), 32'(!m_valid[i] || out_ready));
      if (m_valid[i]) begin
        chk($sformatf("n_a%0d", i), 32'(na[i]), 32'(m_na[i]));
        chk($sformatf("n_b%0d", i), 32'(nb[i]), 32'(m_nb[i]));
        chk($sformatf("reg_a%0d", i), 32'(da[i]), 32'(m_da[i]));
        chk($sformatf("reg_b%0d", i), 32'(db[i]), 32'(m_db[i]));
        chk($sformatf("sel_err%0d", i), 32'(se[i]), 32'(m_err[i]));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 32'(ov[i]), 32'd0);
      chk($sformatf("%s_na%0d", tag, i), 32'(na[i]), 32'd0);
      chk($sformatf("%s_nb%0d", tag, i), 32'(nb[i]), 32'd0);
      chk($sformatf("%s_da%0d", tag, i), 32'(da[i]), 32'd0);
      chk($sformatf("%s_db%0d", tag, i), 32'(db[i]), 32'd0);
      chk($sformatf("%s_err%0d", tag, i), 32'(se[i]), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int vcount;
    for (int k = 0; k < 8; k++) rf[k] = 16'h1000 + 16'(k);
    model_reset();

    tab[0] = '{3'd3, 3'd5, 1'b0, 3'd0, 16'h0000, 16'h1003, 16'h1005, 16'h1003, 16'h1003, 1'b0};
    tab[1] = '{3'd2, 3'd2, 1'b1, 3'd2, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1'b0};
    tab[2] = '{3'd0, 3'd7, 1'b1, 3'd0, 16'h1234, 16'h1234, 16'h1007, 16'h0000, 16'h1234, 1'b1};
    tab[3] = '{3'd7, 3'd1, 1'b1, 3'd7, 16'h5555, 16'h5555, 16'h1001, 16'h5555, 16'h0000, 1'b1};
    tab[4] = '{3'd1, 3'd6, 1'b0, 3'd1, 16'h7777, 16'h1001, 16'h1006, 16'h1001, 16'h1001, 1'b1};
    tab[5] = '{3'd1, 3'd1, 1'b1, 3'd0, 16'h4321, 16'h1001, 16'h1001, 16'h1001, 16'h1001, 1'b0};

    #2;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table of single-cycle captures with OUT_READY held high.
    for (int r = 0; r < 6; r++) begin
      a = tab[r].a; b = tab[r].b;
      wb_en = tab[r].wb_en; wb_n = tab[r].wb_n; wb_data = tab[r].wb_data;
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk($sformatf("tab%0d_valid", r), 32'(ov[0]), 32'd1);
      chk($sformatf("tab%0d_na", r), 32'(na[0]), 32'(tab[r].a));
      chk($sformatf("tab%0d_a", r), 32'(da[0]), 32'(tab[r].ea));
      chk($sformatf("tab%0d_b", r), 32'(db[0]), 32'(tab[r].eb));
      chk($sformatf("tab%0d_err", r), 32'(se[0]), 32'd0);
      chk($sformatf("tab%0d_za", r), 32'(da[1]), 32'(tab[r].ez));
      chk($sformatf("tab%0d_6a", r), 32'(da[2]), 32'(tab[r].e6));
      chk($sformatf("tab%0d_6err", r), 32'(se[2]), 32'(tab[r].e6err));
    end

    // Asynchronous reset in mid-cycle clears everything without an edge.
    wb_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Capture r4, then stall three cycles with a write-back to r4 in the second.
    a = 3'd4; b = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("stall_cap_a", 32'(da[0]), 32'h1004);
    a = 3'd1; b = 3'd1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wb_en = (c == 1); wb_n = 3'd4; wb_data = 16'h00AA;
      step();
      chk($sformatf("stall%0d_valid", c), 32'(ov[0]), 32'd1);
      chk($sformatf("stall%0d_na", c), 32'(na[0]), 32'd4);
      chk($sformatf("stall%0d_a", c), 32'(da[0]), (c == 0) ? 32'h1004 : 32'h00AA);
      chk($sformatf("stall%0d_b", c), 32'(db[0]), 32'h1005);
      chk($sformatf("stall%0d_ready", c), 32'(ir[0]), 32'd0);
    end
    wb_en = 1'b0;

    // Flush while stalled with a pending request: nothing captured.
    flush = 1'b1; in_valid = 1'b1; a = 3'd2;
    step();
    check_zero("flush");
    flush = 1'b0;

    // Back-to-back stream of eight requests.
    vcount = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a = 3'($urandom); b = 3'($urandom);
      step();
      if (ov[2]) vcount++;
    end
    chk("stream_count", 32'(vcount), 32'd8);
    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(ov[0]), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      wb_en     = ($urandom % 2) == 0;
      wb_n      = 3'($urandom);
      wb_data   = 16'($urandom);
      a         = 3'($urandom);
      b         = 3'($urandom);
      if (($urandom % 8) == 0) begin
        for (int k = 0; k < 8; k++) rf[k] = 16'($urandom);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
